// File: rtl/interval_timer_arbiter_if.sv
// Requester-side bundle for the shared interval timer.
// Optional abort signals exist only with TIMER_ARB_ABORT_EN.
interface interval_timer_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
);
  logic                 CountEn;
  logic [NREQ-1:0]      Req;
  logic [NREQ*W-1:0]    Len;
  logic [NREQ-1:0]      Grant;
  logic [NREQ-1:0]      Done;
  logic                 Busy;
  logic [W-1:0]         Count;
  logic [IDW-1:0]       ActiveId;
`ifdef TIMER_ARB_ABORT_EN
  logic                 Abort;
  logic                 Aborted;
`endif

  modport master (
    output CountEn, Req, Len,
`ifdef TIMER_ARB_ABORT_EN
    output Abort,
    input  Aborted,
`endif
    input  Grant, Done, Busy, Count, ActiveId
  );

  modport slave (
    input  CountEn, Req, Len,
`ifdef TIMER_ARB_ABORT_EN
    input  Abort,
    output Aborted,
`endif
    output Grant, Done, Busy, Count, ActiveId
  );
endinterface

// File: rtl/interval_timer_arbiter.sv
// Round-robin shared interval timer (IDLE/RUN/DONE).
// Define TIMER_ARB_ABORT_EN to add the Abort/Aborted pair.
module interval_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input logic                        Clock,
  input logic                        Reset,
  interval_timer_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic [W-1:0]    r_count;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_ptr;

  logic            w_any;
  logic [IDW-1:0]  w_sel;
  logic [NREQ-1:0] w_onehot;
  logic [W-1:0]    w_len;
  logic [IDW-1:0]  w_ptr_nx;
  logic            w_abort;
  logic            w_end;

`ifdef TIMER_ARB_ABORT_EN
  logic            r_aborted;
  assign w_abort     = bus.Abort;
  assign bus.Aborted = r_aborted;
`else
  assign w_abort     = 1'b0;
`endif

  // Pick first requester at or above the pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_ptr) + k) % NREQ;
      if (bus.Req[idx]) begin
        w_any = 1'b1;
        w_sel = IDW'(idx);
      end
    end
  end

  assign w_onehot = NREQ'(1) << w_sel;
  assign w_len    = bus.Len[w_sel*W +: W];
  assign w_ptr_nx = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
  assign w_end    = w_abort || (bus.CountEn && (r_count == '0));

  // Timer ownership FSM with registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
`ifdef TIMER_ARB_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_RUN;
            r_grant <= w_onehot;
            r_id    <= w_sel;
            r_count <= w_len;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_end) begin
            r_state   <= S_DONE;
            r_done    <= r_grant;
`ifdef TIMER_ARB_ABORT_EN
            r_aborted <= w_abort;
`endif
          end else if (bus.CountEn) begin
            r_count <= r_count - 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_done    <= '0;
          r_grant   <= '0;
          r_busy    <= 1'b0;
          r_count   <= '0;
          r_ptr     <= w_ptr_nx;
`ifdef TIMER_ARB_ABORT_EN
          r_aborted <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Grant    = r_grant;
  assign bus.Done     = r_done;
  assign bus.Busy     = r_busy;
  assign bus.Count    = r_count;
  assign bus.ActiveId = r_id;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Bench for interval_timer_arbiter: directed cases plus
// randomized traffic against a behavioural owner/ticks model.
module tb_interval_timer_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  interval_timer_arbiter_if #(
    .NREQ(NREQ), .W(W), .IDW(IDW)
  ) bus ();

  interval_timer_arbiter #(
    .NREQ(NREQ), .W(W), .IDW(IDW)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic m_abort_in;
`ifdef TIMER_ARB_ABORT_EN
  assign m_abort_in = bus.Abort;
`else
  assign m_abort_in = 1'b0;
`endif

  // Model: phase 0 idle, 1 timing, 2 done-pulse.
  int m_phase;
  int m_owner;
  int m_left;
  int m_ptr;
  bit m_ab;

  function automatic int pick(input logic [NREQ-1:0] r,
                              input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  function automatic int len_of(input int i);
    return int'(bus.Len[i*W +: W]);
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_phase <= 0;
      m_owner <= 0;
      m_left  <= 0;
      m_ptr   <= 0;
      m_ab    <= 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.Req != '0) begin
          m_phase <= 1;
          m_owner <= pick(bus.Req, m_ptr);
          m_left  <= len_of(pick(bus.Req, m_ptr));
          m_ab    <= 1'b0;
        end
        1: if (m_abort_in) begin
          m_phase <= 2;
          m_ab    <= 1'b1;
        end else if (bus.CountEn) begin
          if (m_left == 0) m_phase <= 2;
          else m_left <= m_left - 1;
        end
        default: begin
          m_phase <= 0;
          m_ptr   <= (m_owner + 1) % NREQ;
          m_left  <= 0;
          m_ab    <= 1'b0;
        end
      endcase
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int own1h;
    own1h = 1 << m_owner;
    chk("m_grant", 32'(bus.Grant), m_phase != 0 ? own1h : 0);
    chk("m_done", 32'(bus.Done), m_phase == 2 ? own1h : 0);
    chk("m_busy", 32'(bus.Busy), m_phase != 0 ? 1 : 0);
    chk("m_count", 32'(bus.Count), m_phase != 0 ? m_left : 0);
    chk("m_id", 32'(bus.ActiveId), m_owner);
`ifdef TIMER_ARB_ABORT_EN
    chk("m_aborted", 32'(bus.Aborted),
        (m_phase == 2 && m_ab) ? 1 : 0);
`endif
  endtask

  task automatic step();
    @(negedge Clock);
    if (!Reset) cmp_model();
  endtask

  task automatic set_len(input int i, input int v);
    bus.Len[i*W +: W] = W'(v);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.Req = '0;
    bus.CountEn = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Runs CountEn per mode until a Done pulse; counts ticks used.
  task automatic wait_done(input int mode,
                           output int id,
                           output int ticks);
    int   cyc;
    logic ce;
    logic was_run;
    cyc   = 0;
    ticks = 0;
    id    = -1;
    while (cyc < 400) begin
      case (mode)
        0:       ce = 1'b1;
        1:       ce = (cyc % 3 == 0);
        default: ce = 1'($urandom_range(0, 1));
      endcase
      bus.CountEn = ce;
      was_run = bus.Busy && (bus.Done == '0);
      step();
      cyc++;
      if (was_run && ce) ticks++;
      if (bus.Done != '0) begin
        for (int i = 0; i < NREQ; i++)
          if (bus.Done[i]) id = i;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL wait_done: no Done within 400 cycles");
  endtask

  initial begin
    int id;
    int tk;
    bus.Req     = '0;
    bus.Len     = '0;
    bus.CountEn = 1'b0;
`ifdef TIMER_ARB_ABORT_EN
    bus.Abort   = 1'b0;
`endif
    repeat (2) @(negedge Clock);
    chk("rst_grant", 32'(bus.Grant), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_count", 32'(bus.Count), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_id", 32'(bus.ActiveId), 0);
    Reset = 1'b0;

    // Single requester, Len=3, continuous ticks.
    bus.Req = 4'b0001;
    set_len(0, 3);
    bus.CountEn = 1'b1;
    step();
    chk("t1_grant", 32'(bus.Grant), 1);
    chk("t1_c3", 32'(bus.Count), 3);
    bus.Req = '0;
    step(); chk("t1_c2", 32'(bus.Count), 2);
    step(); chk("t1_c1", 32'(bus.Count), 1);
    step(); chk("t1_c0", 32'(bus.Count), 0);
    chk("t1_nodone", 32'(bus.Done), 0);
    step(); chk("t1_done", 32'(bus.Done), 1);
    chk("t1_busyd", 32'(bus.Busy), 1);
    step(); chk("t1_idle", 32'(bus.Busy), 0);
    chk("t1_done0", 32'(bus.Done), 0);

    // All requesting: rotation 0,1,2,3,0 with an idle gap.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    bus.Req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(0, id, tk);
      chk("t2_id", 32'(id), n % NREQ);
      chk("t2_ticks", 32'(tk), 2);
      step();
      chk("t2_gap", 32'(bus.Busy), 0);
    end
    bus.Req = '0;
    step();

    // Len=0 with sparse ticks: one tick ends it.
    do_reset();
    set_len(2, 0);
    bus.Req = 4'b0100;
    wait_done(1, id, tk);
    bus.Req = '0;
    chk("t3_id", 32'(id), 2);
    chk("t3_ticks", 32'(tk), 1);
    chk("t3_count", 32'(bus.Count), 0);
    step();

    // Stalled ticks hold Count.
    do_reset();
    set_len(1, 20);
    bus.Req = 4'b0010;
    bus.CountEn = 1'b0;
    step();
    chk("t4_grant", 32'(bus.Grant), 2);
    bus.Req = '0;
    repeat (30) step();
    chk("t4_hold", 32'(bus.Count), 20);
    chk("t4_nodone", 32'(bus.Done), 0);
    chk("t4_busy", 32'(bus.Busy), 1);
    wait_done(0, id, tk);
    chk("t4_id", 32'(id), 1);
    chk("t4_ticks", 32'(tk), 21);
    step();

    // Async reset mid-interval, pointer returns to 0.
    do_reset();
    set_len(0, 10);
    bus.Req = 4'b0001;
    bus.CountEn = 1'b1;
    step();
    bus.Req = 4'b1000;
    step();
    step();
    step();
    chk("t5_c7", 32'(bus.Count), 7);
    #2 Reset = 1'b1;
    #1;
    chk("t5_grant0", 32'(bus.Grant), 0);
    chk("t5_busy0", 32'(bus.Busy), 0);
    chk("t5_count0", 32'(bus.Count), 0);
    chk("t5_id0", 32'(bus.ActiveId), 0);
    bus.Req = 4'b1010;
    @(negedge Clock);
    Reset = 1'b0;
    step();
    chk("t5_grant", 32'(bus.Grant), 2);
    chk("t5_id", 32'(bus.ActiveId), 1);
    bus.Req = '0;
    wait_done(0, id, tk);
    step();

    // Abort at Count=5 (or natural end without it).
    do_reset();
    set_len(3, 9);
    bus.Req = 4'b1000;
    bus.CountEn = 1'b1;
    step();
    bus.Req = '0;
    repeat (4) step();
    chk("t6_c5", 32'(bus.Count), 5);
`ifdef TIMER_ARB_ABORT_EN
    bus.Abort = 1'b1;
    step();
    bus.Abort = 1'b0;
    chk("t6_done", 32'(bus.Done), 8);
    chk("t6_aborted", 32'(bus.Aborted), 1);
    step();
    chk("t6_idle", 32'(bus.Busy), 0);
`else
    wait_done(0, id, tk);
    chk("t6_id", 32'(id), 3);
    chk("t6_ticks", 32'(tk), 6);
    chk("t6_count", 32'(bus.Count), 0);
    step();
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) bus.Req[i] = ~bus.Req[i];
        if ($urandom_range(0, 7) == 0)
          set_len(i, int'($urandom_range(0, 6)));
      end
      bus.CountEn = ($urandom_range(0, 3) != 0);
`ifdef TIMER_ARB_ABORT_EN
      bus.Abort = ($urandom_range(0, 19) == 0);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
